// File: rtl/single_port_sync_ram_large.sv
// Single-port synchronous RAM, 2^ADDR_WIDTH words in four equal banks, on a shared tri-state data bus.
// One-clock read latency, one access per clock in any read/write mix, never stalls.

module sp_ram_bank #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdat,
  output logic [DATA_WIDTH-1:0] rdat
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdat_d;
  logic [DATA_WIDTH-1:0] rdat_q;
  logic                  wr_en;

  assign wr_en = cs && we && !rst;

  // Storage deliberately has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wdat;
    end
  end

  always_comb begin
    rdat_d = rdat_q;
    if (cs && !we) begin
      rdat_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdat_q <= '0;
    end else begin
      rdat_q <= rdat_d;
    end
  end

  assign rdat = rdat_q;
endmodule

module single_port_sync_ram_large #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs_input,
  input  logic                  we,
  input  logic                  oe
);
  localparam int BANK_AW = ADDR_WIDTH - 2;

  logic [1:0]            bank_sel;
  logic [BANK_AW-1:0]    bank_addr;
  logic [3:0]            bank_cs;
  logic [DATA_WIDTH-1:0] bank_rdat [4];
  logic [1:0]            bsel_d;
  logic [1:0]            bsel_q;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  drv_en;

  assign bank_sel  = addr[ADDR_WIDTH-1 -: 2];
  assign bank_addr = addr[BANK_AW-1:0];
  assign bank_cs   = cs_input ? (4'b0001 << bank_sel) : 4'b0000;

  for (genvar k = 0; k < 4; k++) begin : g_bank
    sp_ram_bank #(
      .ADDR_WIDTH(BANK_AW),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_bank (
      .clk (clk),
      .rst (rst),
      .cs  (bank_cs[k]),
      .we  (we),
      .addr(bank_addr),
      .wdat(data),
      .rdat(bank_rdat[k])
    );
  end

  // Bank select is captured with the read so a later addr change cannot re-steer the output.
  always_comb begin
    bsel_d = bsel_q;
    if (cs_input && !we) begin
      bsel_d = bank_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bsel_q <= 2'b00;
    end else begin
      bsel_q <= bsel_d;
    end
  end

  assign rd_mux = bank_rdat[bsel_q];
  assign drv_en = cs_input && oe && !we && !rst;
  assign data   = drv_en ? rd_mux : {DATA_WIDTH{1'bz}};
endmodule

// File: tb/tb_single_port_sync_ram_large.sv
// Bench for single_port_sync_ram_large: directed vector table, hand-written reset/tri-state
// sequences, then random accesses against a sparse word model. A floating bus reads as all ones.
`timescale 1ns/1ps
module tb_single_port_sync_ram_large;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam logic [DW-1:0] HIZ = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs = 1'b0;
  logic          we = 1'b0;
  logic          oe = 1'b0;
  logic [AW-1:0] addr = '0;
  logic          tb_drv = 1'b0;
  logic [DW-1:0] tb_wdat = '0;
  tri1  [DW-1:0] data_bus;

  assign data_bus = tb_drv ? tb_wdat : {DW{1'bz}};

  single_port_sync_ram_large #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .data    (data_bus),
    .cs_input(cs),
    .we      (we),
    .oe      (oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] model [logic [AW-1:0]];

  typedef struct {
    logic          cs;
    logic          we;
    logic          oe;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat;
    logic [DW-1:0] exp;
    bit            chk;
    int            grp;
  } vec_t;

  vec_t          vecs [$];
  logic [DW-1:0] wr_words [16];
  logic [AW-1:0] pool [$];

  function automatic string grp_name(input int g);
    case (g)
      0: return "edge_wr";
      1: return "edge_rd";
      2: return "alias";
      3: return "cs_off";
      4: return "oe_gate";
      default: return "misc";
    endcase
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    do w = $urandom; while (w == HIZ);
    return w;
  endfunction

  function automatic void add_vec(input logic c, input logic w, input logic o,
                                  input logic [AW-1:0] a, input logic [DW-1:0] wd,
                                  input logic [DW-1:0] e, input bit k, input int g);
    vec_t v;
    v.cs = c; v.we = w; v.oe = o; v.addr = a; v.wdat = wd; v.exp = e; v.chk = k; v.grp = g;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h required=%h", nm, got, exp);
    end
  endtask

  // One clocked access: inputs applied on the falling edge, bus sampled 1ns after the rising edge.
  task automatic access(input logic c, input logic w, input logic o, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, output logic [DW-1:0] got);
    @(negedge clk);
    cs = c; we = w; oe = o; addr = a; tb_wdat = wd; tb_drv = w;
    @(posedge clk);
    if (c && w && !rst) model[a] = wd;
    #1;
    got = data_bus;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] got;
    logic [DW-1:0] exp_v;
    logic [AW-1:0] a;
    logic          c, w, o;
    bit            chk;

    // Reset state: bus floats during reset, read register and bank select clear.
    rst = 1'b1; cs = 1'b1; oe = 1'b1; we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hiz", data_bus, HIZ);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_rdreg_zero", data_bus, '0);

    // Directed vector table.
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 4; i++) begin
        wr_words[b*4+i] = rnd_word();
        add_vec(1, 1, 0, {2'(b), 22'h3FFFFC} + AW'(i), wr_words[b*4+i], '0, 0, 0);
      end
    end
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 4; i++) begin
        add_vec(1, 0, 1, {2'(b), 22'h3FFFFC} + AW'(i), '0, wr_words[b*4+i], 1, 1);
      end
    end
    add_vec(1, 1, 0, 24'h3FFFFF, 32'hAAAA5555, '0, 0, 2);
    add_vec(1, 1, 0, 24'h400000, 32'h12345678, '0, 0, 2);
    add_vec(1, 0, 1, 24'h3FFFFF, '0, 32'hAAAA5555, 1, 2);
    add_vec(1, 0, 1, 24'h400000, '0, 32'h12345678, 1, 2);
    add_vec(1, 1, 0, 24'h000010, 32'h00000001, '0, 0, 3);
    add_vec(0, 1, 0, 24'h000010, 32'hDEADBEEF, '0, 0, 3);
    add_vec(0, 0, 1, 24'h000010, '0, HIZ, 1, 3);
    add_vec(1, 0, 1, 24'h000010, '0, 32'h00000001, 1, 3);
    add_vec(1, 0, 0, 24'h3FFFFC, '0, HIZ, 1, 4);
    add_vec(1, 1, 1, 24'h000020, 32'h5A5A1234, '0, 0, 4);
    add_vec(1, 0, 1, 24'h000020, '0, 32'h5A5A1234, 1, 4);
    add_vec(1, 0, 1, 24'hFFFFFF, '0, wr_words[15], 1, 1);
    add_vec(1, 0, 1, 24'hC00000, '0, '0, 0, 5);

    foreach (vecs[i]) begin
      access(vecs[i].cs, vecs[i].we, vecs[i].oe, vecs[i].addr, vecs[i].wdat, got);
      if (vecs[i].chk) check($sformatf("vec%0d_%s", i, grp_name(vecs[i].grp)), got, vecs[i].exp);
    end

    // Output enable / write priority gate the bus combinationally; held word follows the read's bank.
    access(1, 1, 0, 24'h123456, 32'h0BADC0DE, got);
    access(1, 0, 1, 24'h123456, '0, got);
    check("hold_read", got, 32'h0BADC0DE);
    #1; oe = 1'b0;
    #1; check("oe_off_hiz", data_bus, HIZ);
    oe = 1'b1;
    #1; check("oe_on_again", data_bus, 32'h0BADC0DE);
    addr = 24'h923456;
    #1; check("addr_change_no_resteer", data_bus, 32'h0BADC0DE);
    we = 1'b1;
    #1; check("we_high_hiz", data_bus, HIZ);
    we = 1'b0;
    #1; check("we_low_again", data_bus, 32'h0BADC0DE);
    cs = 1'b0;
    #1; check("cs_off_hiz", data_bus, HIZ);

    // Asynchronous reset between edges, reset across a read edge, contents retained.
    access(1, 1, 0, 24'h800000, 32'hCAFEF00D, got);
    access(1, 0, 1, 24'h800000, '0, got);
    check("pre_rst_read", got, 32'hCAFEF00D);
    #1; rst = 1'b1;
    #1; check("rst_pulse_hiz", data_bus, HIZ);
    rst = 1'b0;
    #1; check("rst_pulse_cleared", data_bus, '0);
    rst = 1'b1;
    @(posedge clk);
    #1; check("rst_hold_hiz", data_bus, HIZ);
    @(negedge clk);
    rst = 1'b0;
    #1; check("rst_read_cancelled", data_bus, '0);
    access(1, 0, 1, 24'h800000, '0, got);
    check("post_rst_read", got, 32'hCAFEF00D);
    access(1, 0, 1, 24'h3FFFFF, '0, got);
    check("post_rst_other_bank", got, 32'hAAAA5555);

    // Random accesses against the sparse model.
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 4; i++) pool.push_back({2'(b), 22'h3FFFFC} + AW'(i));
    pool.push_back(24'h400000);
    pool.push_back(24'h000000);
    for (int i = 0; i < 16; i++) pool.push_back(AW'($urandom));

    for (int n = 0; n < 300; n++) begin
      a = pool[$urandom_range(0, pool.size() - 1)];
      c = ($urandom_range(0, 7) != 0);
      w = 1'($urandom_range(0, 1));
      o = 1'($urandom_range(0, 1));
      chk = 0;
      exp_v = HIZ;
      if (!w) begin
        if (c && o) begin
          if (model.exists(a)) begin
            chk = 1;
            exp_v = model[a];
          end
        end else begin
          chk = 1;
        end
      end
      access(c, w, o, a, rnd_word(), got);
      if (chk) check($sformatf("rand%0d_a%h", n, a), got, exp_v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/single_port_sync_ram_large.md
SINGLE_PORT_SYNC_RAM_LARGE -- requirements
Module: single_port_sync_ram_large

Interface
REQ-001: Parameter ADDR_WIDTH, default 24, word-address width; SHALL be at least 3.
REQ-002: Parameter DATA_WIDTH, default 32, word width in bits.
REQ-003: Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004: Port rst  input  1  reset, asynchronous and active-high.
REQ-005: Port addr  input  ADDR_WIDTH  word address.
REQ-006: Port data  inout  DATA_WIDTH  bidirectional data bus: write data in, read data out.
REQ-007: Port cs_input  input  1  chip select, active-high.
REQ-008: Port we  input  1  write enable, active-high.
REQ-009: Port oe  input  1  output enable, active-high.

Function
REQ-010: Capacity SHALL be 2^ADDR_WIDTH words of DATA_WIDTH bits (default 16M x 32).
REQ-011: Storage SHALL be four equal banks of 2^(ADDR_WIDTH-2) words each, built from one parameterised bank submodule instanced four times.
REQ-012: Bank select SHALL be addr[ADDR_WIDTH-1:ADDR_WIDTH-2]; addr[ADDR_WIDTH-3:0] SHALL be the in-bank address.
REQ-013: Bank k's chip select SHALL be cs_input AND (addr top bits == k); exactly one bank SHALL be selected when cs_input=1, none when cs_input=0.
REQ-014: Write: on a rising clk with cs_input=1 and we=1, the word on data SHALL be stored at addr, visible to reads from the next cycle.
REQ-015: Read: on a rising clk with cs_input=1 and we=0, the selected bank SHALL register mem[addr] into its read register; read latency is one clock.
REQ-016: The module SHALL drive data with the selected bank's read register only while cs_input=1, oe=1 and we=0; otherwise data SHALL be high-impedance on every bit.
REQ-017: The read-data mux SHALL be steered by the bank-select bits registered with the read, so the output stays with the addressed bank's word even if addr changes after the edge.
REQ-018: we=1 together with oe=1 SHALL perform the write and SHALL NOT drive data; write has priority.
REQ-019: With cs_input=0, no storage location and no read register SHALL change, and data SHALL be high-impedance.
REQ-020: Unselected banks SHALL hold their read registers and contents unchanged.
REQ-021: Back-to-back accesses to any banks, in any mix of reads and writes, SHALL run at one access per clock with no stall.
REQ-022: Never-written locations SHALL read as undefined; all written locations SHALL retain their values indefinitely.
REQ-023: Addresses at bank boundaries (bank base and base-1) SHALL map to distinct banks with no aliasing between banks.

Reset
REQ-024: Asserting rst SHALL immediately clear all bank read registers and the registered bank select to 0, without waiting for a clock edge.
REQ-025: While rst=1, writes and reads SHALL be ignored and data SHALL be high-impedance.
REQ-026: Reset SHALL NOT clear memory contents; words written before reset SHALL read back unchanged after reset deasserts.
REQ-027: Reset asserted mid-read SHALL cancel that read; the first read after deassertion SHALL complete with normal one-cycle latency.

Verification
REQ-028: Write four random words to each of 0x3FFFFC-0x3FFFFF, 0x7FFFFC-0x7FFFFF, 0xBFFFFC-0xBFFFFF and 0xFFFFFC-0xFFFFFF (cs_input=1, we=1, oe=0); read all 16 back (we=0, oe=1) -> each read returns its written word one clock after its address edge.
REQ-029: Write 0xAAAA5555 to 0x3FFFFF and 0x12345678 to 0x400000, then read both -> each returns its own value, confirming no bank aliasing.
REQ-030: With cs_input=0 and we=1, drive 0xDEADBEEF at 0x000010 (previously written 0x1) -> a later read returns 0x1; data stays high-impedance while cs_input=0.
REQ-031: Read a written address, then deassert oe (or set we=1) -> data goes high-impedance with no clock edge required; reassert oe -> the held word reappears.
REQ-032: Write 0xCAFEF00D to 0x800000, then pulse rst between clock edges -> read register clears to 0 at once and data is high-impedance during reset; after reset, reading 0x800000 returns 0xCAFEF00D.
